// File: rtl/mem_responder_if.sv
// Request opcode type and the MemBus link between the cache and main memory.
package pkg;
  typedef enum logic [1:0] {
    INVALID = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2
  } Op;
endpackage

interface MemBus;
  logic       rst;
  pkg::Op     req_op;
  logic [5:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_vld;
  logic [7:0] rsp_data;

  modport responder (input rst, req_op, req_addr, req_data, output rsp_vld, rsp_data);
  modport requester (output rst, req_op, req_addr, req_data, input rsp_vld, rsp_data);
endinterface

// File: rtl/mem_responder.sv
// Main-memory responder: 64x8 store, immediate writes, reads answered after
// LATENCY edges through a valid/data delay line, saturating request counters.
module mem_responder #(
  parameter int LATENCY   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  MemBus.responder             bus,
  output logic [CNT_WIDTH-1:0] n_reads,
  output logic [CNT_WIDTH-1:0] n_writes
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [7:0]           r_mem [64];
  logic                 r_rsp_vld;
  logic [7:0]           r_rsp_data;
  logic [CNT_WIDTH-1:0] r_n_reads;
  logic [CNT_WIDTH-1:0] r_n_writes;
  logic                 w_rd;
  logic                 w_wr;
  logic [7:0]           w_cap_data;
  logic                 w_tail_vld;
  logic [7:0]           w_tail_data;

  // A request on a bus-reset edge is dropped.
  assign w_rd       = !bus.rst && (bus.req_op == pkg::READ);
  assign w_wr       = !bus.rst && (bus.req_op == pkg::WRITE);
  assign w_cap_data = r_mem[bus.req_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 64; a++) begin
        r_mem[a] <= {2'b00, 6'(a)};
      end
    end else if (w_wr) begin
      r_mem[bus.req_addr] <= bus.req_data;
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign w_tail_vld  = w_rd;
      assign w_tail_data = w_cap_data;
    end else begin : g_delay
      localparam int STAGES = LATENCY - 1;
      logic [STAGES-1:0] r_dl_vld;
      logic [7:0]        r_dl_data [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dl_vld <= '0;
          for (int i = 0; i < STAGES; i++) begin
            r_dl_data[i] <= 8'h00;
          end
        end else begin
          r_dl_vld[0]  <= w_rd;
          r_dl_data[0] <= w_cap_data;
          for (int i = 1; i < STAGES; i++) begin
            r_dl_vld[i]  <= r_dl_vld[i-1];
            r_dl_data[i] <= r_dl_data[i-1];
          end
          if (bus.rst) begin
            r_dl_vld <= '0;
          end
        end
      end

      assign w_tail_vld  = r_dl_vld[STAGES-1];
      assign w_tail_data = r_dl_data[STAGES-1];
    end
  endgenerate

  // Output stage: data only moves with a valid response so it holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= 8'h00;
    end else if (bus.rst) begin
      r_rsp_vld <= 1'b0;
    end else begin
      r_rsp_vld <= w_tail_vld;
      if (w_tail_vld) begin
        r_rsp_data <= w_tail_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_reads  <= '0;
      r_n_writes <= '0;
    end else if (bus.rst) begin
      r_n_reads  <= '0;
      r_n_writes <= '0;
    end else begin
      if (w_rd && (r_n_reads != '1)) begin
        r_n_reads <= r_n_reads + CNT_ONE;
      end
      if (w_wr && (r_n_writes != '1)) begin
        r_n_writes <= r_n_writes + CNT_ONE;
      end
    end
  end

  assign bus.rsp_vld  = r_rsp_vld;
  assign bus.rsp_data = r_rsp_data;
  assign n_reads      = r_n_reads;
  assign n_writes     = r_n_writes;
endmodule

// File: tb/tb_mem_responder.sv
// Drives identical request streams into three responders (LATENCY 2/4/1) and
// checks them against a queue-based reference model of memory and responses.
module tb_mem_responder;
  localparam int LAT  [3] = '{2, 4, 1};
  localparam int CMAX [3] = '{65535, 65535, 3};

  typedef struct {
    int         d;
    int         due;
    logic [7:0] data;
  } ent_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       t_rst  = 1'b0;
  pkg::Op     t_op   = pkg::INVALID;
  logic [5:0] t_addr = 6'd0;
  logic [7:0] t_data = 8'd0;

  logic [15:0] nr0, nw0, nr1, nw1;
  logic [1:0]  nr2, nw2;
  logic        obs_vld  [3];
  logic [7:0]  obs_data [3];
  logic [15:0] obs_nr   [3];
  logic [15:0] obs_nw   [3];

  logic [7:0] m_mem [64];
  int         m_reads;
  int         m_writes;
  int         edge_no = 0;
  logic       e_vld  [3];
  logic [7:0] e_data [3];
  ent_t       pend [$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  MemBus b0 ();
  MemBus b1 ();
  MemBus b2 ();

  assign b0.rst = t_rst;  assign b0.req_op = t_op;  assign b0.req_addr = t_addr;  assign b0.req_data = t_data;
  assign b1.rst = t_rst;  assign b1.req_op = t_op;  assign b1.req_addr = t_addr;  assign b1.req_data = t_data;
  assign b2.rst = t_rst;  assign b2.req_op = t_op;  assign b2.req_addr = t_addr;  assign b2.req_data = t_data;

  mem_responder #(.LATENCY(2), .CNT_WIDTH(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0), .n_reads(nr0), .n_writes(nw0));
  mem_responder #(.LATENCY(4), .CNT_WIDTH(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .n_reads(nr1), .n_writes(nw1));
  mem_responder #(.LATENCY(1), .CNT_WIDTH(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(b2), .n_reads(nr2), .n_writes(nw2));

  assign obs_vld[0]  = b0.rsp_vld;  assign obs_data[0] = b0.rsp_data;
  assign obs_vld[1]  = b1.rsp_vld;  assign obs_data[1] = b1.rsp_data;
  assign obs_vld[2]  = b2.rsp_vld;  assign obs_data[2] = b2.rsp_data;
  assign obs_nr[0] = nr0;            assign obs_nw[0] = nw0;
  assign obs_nr[1] = nr1;            assign obs_nw[1] = nw1;
  assign obs_nr[2] = {14'd0, nr2};   assign obs_nw[2] = {14'd0, nw2};

  function automatic logic [15:0] sat(input int c, input int d);
    return (c > CMAX[d]) ? 16'(CMAX[d]) : 16'(c);
  endfunction

  task automatic model_init();
    for (int a = 0; a < 64; a++) m_mem[a] = 8'(a);
    m_reads  = 0;
    m_writes = 0;
    pend.delete();
    for (int d = 0; d < 3; d++) begin
      e_vld[d]  = 1'b0;
      e_data[d] = 8'h00;
    end
  endtask

  // One clock of stimulus; the model advances at the edge, outputs are sampled 1 unit later.
  task automatic step(input pkg::Op op, input logic [5:0] a, input logic [7:0] dat, input logic r);
    ent_t e;
    t_op = op; t_addr = a; t_data = dat; t_rst = r;
    @(posedge clk);
    edge_no++;
    if (r) begin
      pend.delete();
      m_reads  = 0;
      m_writes = 0;
      for (int d = 0; d < 3; d++) e_vld[d] = 1'b0;
    end else begin
      if (op == pkg::READ) begin
        for (int d = 0; d < 3; d++) begin
          e.d = d; e.due = edge_no + LAT[d] - 1; e.data = m_mem[a];
          pend.push_back(e);
        end
        m_reads++;
      end else if (op == pkg::WRITE) begin
        m_mem[a] = dat;
        m_writes++;
      end
      for (int d = 0; d < 3; d++) e_vld[d] = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].due == edge_no) begin
          e_vld[pend[i].d]  = 1'b1;
          e_data[pend[i].d] = pend[i].data;
          pend.delete(i);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    pkg::Op ops [4] = '{pkg::READ, pkg::INVALID, pkg::INVALID, pkg::INVALID};
    #2 rst_n = 1'b0;
    model_init();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs_vld[d] !== 1'b0 || obs_data[d] !== 8'h00 || obs_nr[d] !== 16'd0 || obs_nw[d] !== 16'd0) begin
        failures++;
        $display("FAIL reset_vals dut%0d: vld=%b data=%h nr=%0d nw=%0d, want all zero", d, obs_vld[d], obs_data[d], obs_nr[d], obs_nw[d]);
      end
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(ops[i], 6'h2A, 8'h00, 1'b0);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs_vld[d] !== e_vld[d] || obs_data[d] !== e_data[d] || obs_nr[d] !== sat(m_reads, d) || obs_nw[d] !== sat(m_writes, d)) begin
          failures++;
          $display("FAIL reset_read dut%0d edge%0d: vld=%b data=%h nr=%0d nw=%0d, want vld=%b data=%h nr=%0d nw=%0d", d, edge_no, obs_vld[d], obs_data[d], obs_nr[d], obs_nw[d], e_vld[d], e_data[d], sat(m_reads, d), sat(m_writes, d));
        end
      end
      checks++;
      if (obs_vld[0] !== (i == 1) || (i == 1 && (obs_data[0] !== 8'h2A || nr0 !== 16'd1 || nw0 !== 16'd0))) begin
        failures++;
        $display("FAIL reset_init_lat2 step%0d: vld=%b data=%h nr=%0d nw=%0d, want pulse only at step1 with 2a/1/0", i, obs_vld[0], obs_data[0], nr0, nw0);
      end
    end
  endtask

  task automatic test_write_read();
    pkg::Op     ops [5] = '{pkg::INVALID, pkg::WRITE, pkg::READ, pkg::INVALID, pkg::INVALID};
    logic       rs  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(ops[i], 6'h05, 8'hC3, rs[i]);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs_vld[d] !== e_vld[d] || obs_data[d] !== e_data[d] || obs_nr[d] !== sat(m_reads, d) || obs_nw[d] !== sat(m_writes, d)) begin
          failures++;
          $display("FAIL write_read dut%0d edge%0d: vld=%b data=%h nr=%0d nw=%0d, want vld=%b data=%h nr=%0d nw=%0d", d, edge_no, obs_vld[d], obs_data[d], obs_nr[d], obs_nw[d], e_vld[d], e_data[d], sat(m_reads, d), sat(m_writes, d));
        end
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (obs_vld[0] !== (i == 3) || (i == 3 && (obs_data[0] !== 8'hC3 || nr0 !== 16'd1 || nw0 !== 16'd1))) begin
          failures++;
          $display("FAIL write_then_read step%0d: vld=%b data=%h nr=%0d nw=%0d, want pulse at step3 with c3/1/1", i, obs_vld[0], obs_data[0], nr0, nw0);
        end
      end
    end
  endtask

  task automatic test_order_b2b();
    pkg::Op     ops [8] = '{pkg::READ, pkg::WRITE, pkg::READ, pkg::READ, pkg::READ, pkg::INVALID, pkg::INVALID, pkg::INVALID};
    logic [5:0] ads [8] = '{6'h07, 6'h07, 6'h01, 6'h02, 6'h03, 6'h00, 6'h00, 6'h00};
    logic       v0  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       v2  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] d0  [8] = '{8'h00, 8'h07, 8'h07, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03};
    logic [7:0] d2  [8] = '{8'h07, 8'h07, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03};
    for (int i = 0; i < 8; i++) begin
      step(ops[i], ads[i], 8'hFF, 1'b0);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs_vld[d] !== e_vld[d] || obs_data[d] !== e_data[d] || obs_nr[d] !== sat(m_reads, d) || obs_nw[d] !== sat(m_writes, d)) begin
          failures++;
          $display("FAIL order dut%0d edge%0d: vld=%b data=%h nr=%0d nw=%0d, want vld=%b data=%h nr=%0d nw=%0d", d, edge_no, obs_vld[d], obs_data[d], obs_nr[d], obs_nw[d], e_vld[d], e_data[d], sat(m_reads, d), sat(m_writes, d));
        end
      end
      checks++;
      if (obs_vld[0] !== v0[i] || (i > 0 && obs_data[0] !== d0[i]) || obs_vld[2] !== v2[i] || obs_data[2] !== d2[i]) begin
        failures++;
        $display("FAIL b2b_seq step%0d: lat2 %b/%h lat1 %b/%h, want lat2 %b/%h lat1 %b/%h", i, obs_vld[0], obs_data[0], obs_vld[2], obs_data[2], v0[i], d0[i], v2[i], d2[i]);
      end
    end
  endtask

  task automatic test_bus_rst();
    pkg::Op     ops [12] = '{pkg::READ, pkg::WRITE, pkg::INVALID, pkg::INVALID, pkg::INVALID, pkg::INVALID,
                             pkg::READ, pkg::INVALID, pkg::INVALID, pkg::READ, pkg::INVALID, pkg::INVALID};
    logic [5:0] ads [12] = '{6'h20, 6'h10, 6'h00, 6'h00, 6'h00, 6'h00, 6'h10, 6'h00, 6'h00, 6'h05, 6'h00, 6'h00};
    for (int i = 0; i < 12; i++) begin
      step(ops[i], ads[i], 8'h99, (i == 1));
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs_vld[d] !== e_vld[d] || obs_data[d] !== e_data[d] || obs_nr[d] !== sat(m_reads, d) || obs_nw[d] !== sat(m_writes, d)) begin
          failures++;
          $display("FAIL bus_rst dut%0d edge%0d: vld=%b data=%h nr=%0d nw=%0d, want vld=%b data=%h nr=%0d nw=%0d", d, edge_no, obs_vld[d], obs_data[d], obs_nr[d], obs_nw[d], e_vld[d], e_data[d], sat(m_reads, d), sat(m_writes, d));
        end
      end
      if (i >= 1 && i <= 5) begin
        checks++;
        if (obs_vld[0] !== 1'b0 || obs_vld[1] !== 1'b0 || obs_vld[2] !== 1'b0 || nr0 !== 16'd0 || nw0 !== 16'd0) begin
          failures++;
          $display("FAIL bus_rst_cancel step%0d: vld=%b%b%b nr=%0d nw=%0d, want 000/0/0", i, obs_vld[0], obs_vld[1], obs_vld[2], nr0, nw0);
        end
      end
      if (i == 7 || i == 10) begin
        checks++;
        if (obs_vld[0] !== 1'b1 || obs_data[0] !== ((i == 7) ? 8'h10 : 8'hC3)) begin
          failures++;
          $display("FAIL bus_rst_retain step%0d: vld=%b data=%h, want 1/%h", i, obs_vld[0], obs_data[0], (i == 7) ? 8'h10 : 8'hC3);
        end
      end
    end
  endtask

  task automatic test_async_rst();
    step(pkg::READ, 6'h30, 8'h00, 1'b0);
    step(pkg::INVALID, 6'h00, 8'h00, 1'b0);
    step(pkg::INVALID, 6'h00, 8'h00, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs_vld[d] !== 1'b0 || obs_data[d] !== 8'h00 || obs_nr[d] !== 16'd0 || obs_nw[d] !== 16'd0) begin
        failures++;
        $display("FAIL async_rst_now dut%0d: vld=%b data=%h nr=%0d nw=%0d, want all zero", d, obs_vld[d], obs_data[d], obs_nr[d], obs_nw[d]);
      end
    end
    model_init();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(pkg::INVALID, 6'h00, 8'h00, 1'b0);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs_vld[d] !== 1'b0 || obs_vld[d] !== e_vld[d] || obs_data[d] !== e_data[d] || obs_nr[d] !== sat(m_reads, d)) begin
          failures++;
          $display("FAIL async_rst_after dut%0d edge%0d: vld=%b data=%h nr=%0d, want vld=0 data=%h nr=%0d", d, edge_no, obs_vld[d], obs_data[d], obs_nr[d], e_data[d], sat(m_reads, d));
        end
      end
    end
  endtask

  task automatic test_saturation();
    step(pkg::INVALID, 6'h00, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step((i < 5) ? pkg::WRITE : pkg::READ, 6'(40 + i), 8'(8'h50 + i), 1'b0);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs_vld[d] !== e_vld[d] || obs_data[d] !== e_data[d] || obs_nr[d] !== sat(m_reads, d) || obs_nw[d] !== sat(m_writes, d)) begin
          failures++;
          $display("FAIL saturation dut%0d edge%0d: vld=%b data=%h nr=%0d nw=%0d, want vld=%b data=%h nr=%0d nw=%0d", d, edge_no, obs_vld[d], obs_data[d], obs_nr[d], obs_nw[d], e_vld[d], e_data[d], sat(m_reads, d), sat(m_writes, d));
        end
      end
    end
    checks++;
    if (nw2 !== 2'd3 || nr2 !== 2'd3 || nw0 !== 16'd5 || nr0 !== 16'd4) begin
      failures++;
      $display("FAIL counter_sat: w2=%0d r2=%0d w0=%0d r0=%0d, want 3 3 5 4", nw2, nr2, nw0, nr0);
    end
  endtask

  task automatic test_random();
    pkg::Op     op;
    logic [5:0] a;
    logic [7:0] dat;
    logic       r;
    for (int i = 0; i < 400; i++) begin
      op  = pkg::Op'($urandom_range(0, 2));
      a   = 6'($urandom_range(0, 63));
      dat = 8'($urandom_range(0, 255));
      r   = ($urandom_range(0, 15) == 0);
      step(op, a, dat, r);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs_vld[d] !== e_vld[d] || obs_data[d] !== e_data[d] || obs_nr[d] !== sat(m_reads, d) || obs_nw[d] !== sat(m_writes, d)) begin
          failures++;
          $display("FAIL random dut%0d edge%0d: vld=%b data=%h nr=%0d nw=%0d, want vld=%b data=%h nr=%0d nw=%0d", d, edge_no, obs_vld[d], obs_data[d], obs_nr[d], obs_nw[d], e_vld[d], e_data[d], sat(m_reads, d), sat(m_writes, d));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_order_b2b();
    test_bus_rst();
    test_async_rst();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
